// File: rtl/alu_if.sv
// alu_if: operand/result bundle for the execute-stage ALU
//   A, B  : signed operands (master -> slave)
//   sel   : opcode (master -> slave)
//   Y     : registered result (slave -> master)
//   flag  : registered status {overflow, zero} (slave -> master)
interface alu_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       sel;
    logic [WIDTH-1:0] Y;
    logic [1:0]       flag;
    modport master (output A, B, sel, input Y, flag);
    modport slave (input A, B, sel, output Y, flag);
endinterface

// File: rtl/alu.sv
// alu: signed ALU with one-cycle registered result and {overflow, zero} flags
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears Y and flag
//   bus  : alu_if slave (A, B, sel in; Y, flag out)
module alu #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst,
    alu_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int M = WIDTH - 1;
    logic [WIDTH-1:0] sum, dif, res;
    logic [WIDTH:0] wide;
    logic ovf;
    assign sum = bus.A + bus.B;
    assign dif = bus.A - bus.B;
    // sign-extended subtraction so SLT never sees a wrapped difference
    assign wide = {bus.A[M], bus.A} - {bus.B[M], bus.B};
    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (bus.sel)
            4'd0: begin
                res = sum;
                ovf = (bus.A[M] == bus.B[M]) && (sum[M] != bus.A[M]);
            end
            4'd1: begin
                res = dif;
                ovf = (bus.A[M] != bus.B[M]) && (dif[M] != bus.A[M]);
            end
            4'd2: res = bus.A & bus.B;
            4'd3: res = bus.A | bus.B;
            4'd4: res = bus.A ^ bus.B;
            4'd5: res = ~bus.A;
            4'd6: res = bus.A << bus.B[SW-1:0];
            4'd7: res = WIDTH'($signed(bus.A) >>> bus.B[SW-1:0]);
            4'd8: res = WIDTH'(wide[WIDTH]);
            4'd9: res = bus.B;
            default: res = '0;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.Y <= '0;
            bus.flag <= 2'b00;
        end else begin
            bus.Y <= res;
            bus.flag <= {ovf, res == '0};
        end
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu with directed plan vectors and random ops
module tb_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    alu_if #(.WIDTH(8)) bus ();
    alu #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0] y;
        logic [1:0] f;
        logic [3:0] s;
    } exp_t;
    exp_t q[$];
    int n_checks = 0;
    int n_fail = 0;
    function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic [3:0] s);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int p = 1 << int'(b[2:0]);
        int r = 0;
        logic [7:0] t = 8'h00;
        logic ov = 1'b0;
        exp_t e;
        case (s)
            4'd0: begin r = sa + sb; ov = (r > 127) || (r < -128); end
            4'd1: begin r = sa - sb; ov = (r > 127) || (r < -128); end
            4'd2: begin t = a & b; r = int'(t); end
            4'd3: begin t = a | b; r = int'(t); end
            4'd4: begin t = a ^ b; r = int'(t); end
            4'd5: r = 255 - int'(a);
            4'd6: r = int'(a) * p;
            4'd7: r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
            4'd8: r = (sa < sb) ? 1 : 0;
            4'd9: r = int'(b);
            default: r = 0;
        endcase
        e.y = r[7:0];
        e.f = {ov, e.y == 8'h00};
        e.s = s;
        return e;
    endfunction
    task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask
    task automatic issue(logic [7:0] a, logic [7:0] b, logic [3:0] s);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.sel = s;
        q.push_back(model(a, b, s));
    endtask
    task automatic drain();
        int w = 0;
        while (q.size() > 0 && w < 20) begin
            @(posedge clk);
            w++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!rst && q.size() > 0) begin
                #1;
                e = q.pop_front();
                chk($sformatf("Y sel=%h", e.s), bus.Y, e.y);
                chk($sformatf("flag sel=%h", e.s), {6'd0, bus.flag}, {6'd0, e.f});
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.A = 8'h0C;
        bus.B = 8'h09;
        bus.sel = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset Y", bus.Y, 8'h00);
        chk("reset flag", {6'd0, bus.flag}, 8'h00);
        rst = 1'b0;
        issue(8'h0C, 8'h09, 4'd0);
        issue(8'h0C, 8'h09, 4'd1);
        issue(8'h00, 8'h00, 4'd1);
        issue(8'hCC, 8'hC9, 4'd1);
        issue(8'hCC, 8'hC9, 4'd2);
        issue(8'hCC, 8'hC9, 4'd3);
        issue(8'hCC, 8'hC9, 4'd4);
        issue(8'hCC, 8'hC9, 4'd5);
        issue(8'h0C, 8'h09, 4'd2);
        issue(8'h0C, 8'h09, 4'd3);
        issue(8'h7F, 8'h01, 4'd0);
        issue(8'h80, 8'h01, 4'd1);
        issue(8'hCC, 8'hC9, 4'd0);
        issue(8'hCC, 8'hC9, 4'd6);
        issue(8'hCC, 8'hC9, 4'd7);
        issue(8'hCC, 8'hC9, 4'd8);
        issue(8'h80, 8'h7F, 4'd8);
        issue(8'h7F, 8'h80, 4'd8);
        issue(8'h80, 8'h00, 4'd7);
        issue(8'h81, 8'hF8, 4'd6);
        issue(8'hCC, 8'hC9, 4'b1100);
        issue(8'hFF, 8'hFF, 4'b1111);
        issue(8'hCC, 8'hC9, 4'd9);
        for (int i = 0; i < 300; i++)
            issue(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
        drain();
        issue(8'h00, 8'hC9, 4'd9);
        drain();
        #3;
        chk("pre-reset Y", bus.Y, 8'hC9);
        rst = 1'b1;
        #1;
        chk("async reset Y", bus.Y, 8'h00);
        chk("async reset flag", {6'd0, bus.flag}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        issue(8'h01, 8'h01, 4'd0);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- 8-bit signed arithmetic/logic unit with a registered result and a 2-bit status flag.
- Operands A and B and the 4-bit opcode sel are sampled combinationally. The result and flags are captured on the rising clock edge.
- Used as the execute-stage datapath element of the CPU core.

Parameters:
- WIDTH, 8, operand and result width in bits. All behaviour below is specified at 8.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- A  input  8  signed operand A, two's complement.
- B  input  8  signed operand B, two's complement.
- sel  input  4  operation select.
- Y  output  8  registered signed result.
- flag  output  2  registered status: flag[0]=zero, flag[1]=signed overflow.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high.
- Reset: while rst=1, Y=8'h00 and flag=2'b00, immediately and independent of clk. Operation resumes on the first rising clk edge after rst falls.
- Latency: exactly 1 cycle. The result for the inputs present before rising edge N appears on Y/flag after edge N and holds until the next edge.
- No handshake; a new operation is accepted every cycle.
- Opcodes (result computed combinationally, then registered):
  - 0000 ADD: Y=A+B, modulo 2^8.
  - 0001 SUB: Y=A-B, modulo 2^8.
  - 0010 AND: Y=A&B.
  - 0011 OR: Y=A|B.
  - 0100 XOR: Y=A^B.
  - 0101 NOT: Y=~A; B is ignored.
  - 0110 SLL: Y=A<<B[2:0], zero fill.
  - 0111 SRA: Y=A>>>B[2:0], sign fill.
  - 1000 SLT: Y=8'h01 if A<B (signed comparison), else 8'h00.
  - 1001 PASSB: Y=B.
  - 1010-1111: reserved; Y=8'h00.
- flag[0] (zero): 1 when the registered Y==0, for every opcode, including the reserved ones.
- flag[1] (overflow), ADD: 1 when A and B have the same sign and the result sign differs.
- flag[1] (overflow), SUB: 1 when A and B have different signs and the result sign differs from A.
- flag[1] is 0 for all other opcodes.
- SLT is computed without wrap: the subtraction is done at 9 bits, so overflow cannot corrupt the comparison.
- Shift amount of 0 returns A unchanged. Only B[2:0] is used, so B[7:3] is ignored for shifts.
- Changing sel, A and B in the same cycle is legal; only the values at the clock edge matter.
- Reset asserted mid-stream discards the pending result. No stale value may appear after reset is released.

Test Plan:
- Reset and hold: assert rst with A=8'h0C, B=8'h09, sel=0000 and toggle clk -> Y=8'h00, flag=00. Release rst, one edge -> Y=8'h15, flag=00.
- SUB sequence, one edge each:
  - A=8'h0C, B=8'h09 -> Y=8'h03, flag=00.
  - A=B=8'h00 -> Y=8'h00, flag=01.
  - A=8'hCC, B=8'hC9 -> Y=8'h03, flag=00.
- Logic ops with A=8'hCC, B=8'hC9:
  - AND -> 8'hC8.
  - OR -> 8'hCD.
  - XOR -> 8'h05.
  - NOT -> 8'h33.
  - AND with A=8'h0C, B=8'h09 -> 8'h08.
  - OR with A=8'h0C, B=8'h09 -> 8'h0D.
- Overflow:
  - ADD 8'h7F+8'h01 -> Y=8'h80, flag=10.
  - SUB 8'h80-8'h01 -> Y=8'h7F, flag=10.
  - ADD 8'hCC+8'hC9 -> Y=8'h95, flag=00.
- Shifts and compare with A=8'hCC, B=8'hC9 (shift amount 1):
  - SLL -> 8'h98.
  - SRA -> 8'hE6.
  - SLT -> 8'h00, flag=01.
  - SLT with A=8'h80, B=8'h7F -> 8'h01, flag=00.
- Reserved/PASSB:
  - sel=1100 -> Y=8'h00, flag=01.
  - sel=1001 with B=8'hC9 -> Y=8'hC9.
  - Assert rst asynchronously between edges -> Y/flag go to 0 immediately, without waiting for clk.
